// File: rtl/alu_pkg.sv
// Shared opcode encoding and helpers for the pipelined ALU.
package alu_pkg;

    localparam int unsigned OP_W  = 4;
    localparam int unsigned CNT_W = 4;   // holds a per-byte bit count (0..8)

    typedef enum logic [OP_W-1:0] {
        OP_AND    = 4'd0,
        OP_OR     = 4'd1,
        OP_XOR    = 4'd2,
        OP_NOT    = 4'd3,
        OP_ADD    = 4'd4,
        OP_SUB    = 4'd5,
        OP_INC    = 4'd6,
        OP_SHL    = 4'd7,
        OP_SHR    = 4'd8,
        OP_SRA    = 4'd9,
        OP_POPCNT = 4'd10
    } alu_op_t;

    // Number of set bits in one byte.
    function automatic logic [CNT_W-1:0] popcnt8(input logic [7:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/alu_pipe_popcnt_tree.sv
// Population count split across two stages: per-byte counts, then their sum.
module popcnt_tree
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0]             a,
    output logic [(WIDTH/8)*CNT_W-1:0]   byte_cnt_c,
    input  logic [(WIDTH/8)*CNT_W-1:0]   byte_cnt,
    output logic [WIDTH-1:0]             sum_c
);

    localparam int unsigned NB    = WIDTH / 8;
    localparam int unsigned SUM_W = $clog2(WIDTH + 1);

    logic [SUM_W-1:0] acc;

    // First half: count each byte of the operand independently.
    always_comb begin
        byte_cnt_c = '0;
        for (int i = 0; i < NB; i++) begin
            byte_cnt_c[i*CNT_W +: CNT_W] = popcnt8(a[i*8 +: 8]);
        end
    end

    // Second half: add the registered byte counts and zero-extend.
    always_comb begin
        acc = '0;
        for (int i = 0; i < NB; i++) begin
            acc = acc + SUM_W'(byte_cnt[i*CNT_W +: CNT_W]);
        end
        sum_c = WIDTH'(acc);
    end

endmodule

// File: rtl/alu_pipe.sv
// Three-stage pipelined ALU with valid/ready handshake and a global stall.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] z,
    output logic [TAG_W-1:0] tag_o,
    output logic             zero_o,
    output logic             carry_o,
    output logic             err_o
);

    localparam int unsigned SH_W  = $clog2(WIDTH);
    localparam int unsigned EXT_W = WIDTH + 1;
    localparam int unsigned CW    = (WIDTH / 8) * CNT_W;

    logic stall_c;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    alu_op_t          s1_op;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_res;
    logic             s2_carry;
    logic             s2_err;
    logic             s2_pop;
    logic [CW-1:0]    s2_cnt;
    logic [TAG_W-1:0] s2_tag;

    logic [SH_W-1:0]  sh_c;
    logic [EXT_W-1:0] ext_c;
    logic [WIDTH-1:0] res_c;
    logic             carry_c;
    logic             err_c;
    logic             pop_c;
    logic [CW-1:0]    cnt_c;
    logic [WIDTH-1:0] pop_sum_c;
    logic [WIDTH-1:0] z_c;

    // The whole pipe freezes while a result waits on the output.
    assign stall_c = valid_o & ~ready_i;
    assign ready_o = ~stall_c;
    assign sh_c    = s1_b[SH_W-1:0];

    // Stage 1: capture the request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_AND;
            s1_tag   <= '0;
        end else if (!stall_c) begin
            s1_valid <= valid_i;
            s1_a     <= a;
            s1_b     <= b;
            s1_op    <= alu_op_t'(op);
            s1_tag   <= tag_i;
        end
    end

    // Stage 2 datapath: every op except POPCNT finishes here.
    always_comb begin
        ext_c   = '0;
        res_c   = '0;
        carry_c = 1'b0;
        err_c   = 1'b0;
        pop_c   = 1'b0;
        case (s1_op)
            OP_AND: res_c = s1_a & s1_b;
            OP_OR:  res_c = s1_a | s1_b;
            OP_XOR: res_c = s1_a ^ s1_b;
            OP_NOT: res_c = ~s1_a;
            OP_ADD: begin
                ext_c   = {1'b0, s1_a} + {1'b0, s1_b};
                res_c   = ext_c[WIDTH-1:0];
                carry_c = ext_c[WIDTH];
            end
            OP_SUB: begin
                ext_c   = {1'b0, s1_a} - {1'b0, s1_b};
                res_c   = ext_c[WIDTH-1:0];
                carry_c = ext_c[WIDTH];
            end
            OP_INC: begin
                ext_c   = {1'b0, s1_a} + EXT_W'(1);
                res_c   = ext_c[WIDTH-1:0];
                carry_c = ext_c[WIDTH];
            end
            OP_SHL:    res_c = s1_a << sh_c;
            OP_SHR:    res_c = s1_a >> sh_c;
            OP_SRA:    res_c = WIDTH'($signed(s1_a) >>> sh_c);
            OP_POPCNT: pop_c = 1'b1;
            default:   err_c = 1'b1;
        endcase
    end

    popcnt_tree #(
        .WIDTH (WIDTH)
    ) u_popcnt (
        .a          (s1_a),
        .byte_cnt_c (cnt_c),
        .byte_cnt   (s2_cnt),
        .sum_c      (pop_sum_c)
    );

    // Stage 2: register the result or the per-byte counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_res   <= '0;
            s2_carry <= 1'b0;
            s2_err   <= 1'b0;
            s2_pop   <= 1'b0;
            s2_cnt   <= '0;
            s2_tag   <= '0;
        end else if (!stall_c) begin
            s2_valid <= s1_valid;
            s2_res   <= res_c;
            s2_carry <= carry_c;
            s2_err   <= err_c;
            s2_pop   <= pop_c;
            s2_cnt   <= cnt_c;
            s2_tag   <= s1_tag;
        end
    end

    assign z_c = s2_pop ? pop_sum_c : s2_res;

    // Stage 3: output register; zero flag follows the final result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o <= 1'b0;
            z       <= '0;
            tag_o   <= '0;
            zero_o  <= 1'b0;
            carry_o <= 1'b0;
            err_o   <= 1'b0;
        end else if (!stall_c) begin
            valid_o <= s2_valid;
            z       <= z_c;
            tag_o   <= s2_tag;
            zero_o  <= (z_c == '0);
            carry_o <= s2_carry;
            err_o   <= s2_err;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed cases then a random stream against a queue model.
module tb_alu_pipe;

    localparam int unsigned W  = 64;
    localparam int unsigned TW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_i, ready_o, valid_o, ready_i;
    logic [W-1:0]  a, b, z;
    logic [3:0]    op;
    logic [TW-1:0] tag_i, tag_o;
    logic          zero_o, carry_o, err_o;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .a(a), .b(b), .op(op), .tag_i(tag_i), .valid_o(valid_o),
        .ready_i(ready_i), .z(z), .tag_o(tag_o), .zero_o(zero_o),
        .carry_o(carry_o), .err_o(err_o)
    );

    // adv = number of non-stalled edges seen since acceptance; 3 means on the output
    typedef struct {
        logic [63:0] z;
        logic [3:0]  tag;
        logic        carry;
        logic        err;
        int          adv;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    logic          nvalid, nready;
    logic [63:0]   na, nb;
    logic [3:0]    nop, ntag;
    logic          s_valid, s_zero, s_carry, s_err;
    logic [63:0]   s_z;
    logic [3:0]    s_tag;
    logic          prev_stall = 1'b0;
    logic [63:0]   p_z;
    logic [3:0]    p_tag;
    logic          p_zero, p_carry, p_err;
    logic          acc_in;

    // Reference result from the opcode rules, using plain 64-bit arithmetic.
    function automatic exp_t model(input logic [63:0] x, input logic [63:0] y,
                                   input logic [3:0] o, input logic [3:0] t);
        exp_t e;
        int   sh;
        logic [63:0] ones;
        ones = 64'hFFFF_FFFF_FFFF_FFFF;
        sh = int'(y[5:0]);
        e.z = 64'h0; e.carry = 1'b0; e.err = 1'b0; e.tag = t; e.adv = 1;
        case (o)
            4'd0:  e.z = x & y;
            4'd1:  e.z = x | y;
            4'd2:  e.z = x ^ y;
            4'd3:  e.z = ~x;
            4'd4:  begin e.z = x + y; e.carry = (e.z < x); end
            4'd5:  begin e.z = x - y; e.carry = (x < y); end
            4'd6:  begin e.z = x + 64'd1; e.carry = (x == ones); end
            4'd7:  e.z = x << sh;
            4'd8:  e.z = x >> sh;
            4'd9:  e.z = (x >> sh) | (x[63] ? ~(ones >> sh) : 64'h0);
            4'd10: e.z = 64'($countones(x));
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, expv);
        end
    endtask

    // One cycle: sample and check outputs, apply next inputs, advance the model.
    task automatic tick();
        logic exp_v, stall_e;
        @(negedge clk);
        s_valid = valid_o; s_z = z; s_tag = tag_o;
        s_zero = zero_o; s_carry = carry_o; s_err = err_o;
        exp_v = (q.size() > 0) && (q[0].adv == 3);
        chk("valid_o", 64'(s_valid), 64'(exp_v));
        if (exp_v) begin
            chk("z", s_z, q[0].z);
            chk("tag_o", 64'(s_tag), 64'(q[0].tag));
            chk("zero_o", 64'(s_zero), 64'(q[0].z == 64'h0));
            chk("carry_o", 64'(s_carry), 64'(q[0].carry));
            chk("err_o", 64'(s_err), 64'(q[0].err));
        end
        if (prev_stall) begin
            chk("hold_z", s_z, p_z);
            chk("hold_tag", 64'(s_tag), 64'(p_tag));
            chk("hold_flags", 64'({s_zero, s_carry, s_err}), 64'({p_zero, p_carry, p_err}));
        end
        valid_i = nvalid; a = na; b = nb; op = nop; tag_i = ntag; ready_i = nready;
        #1;
        stall_e = exp_v && !nready;
        chk("ready_o", 64'(ready_o), 64'(!stall_e));
        acc_in = nvalid && !stall_e;
        if (!stall_e) begin
            if (exp_v) void'(q.pop_front());
            for (int i = 0; i < q.size(); i++) q[i].adv = q[i].adv + 1;
            if (acc_in) q.push_back(model(na, nb, nop, ntag));
        end
        prev_stall = stall_e;
        p_z = s_z; p_tag = s_tag; p_zero = s_zero; p_carry = s_carry; p_err = s_err;
    endtask

    task automatic send(input logic [63:0] x, input logic [63:0] y,
                        input logic [3:0] o, input logic [3:0] t);
        nvalid = 1'b1; na = x; nb = y; nop = o; ntag = t;
        tick();
        nvalid = 1'b0;
    endtask

    task automatic idle();
        nvalid = 1'b0;
        tick();
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        nready = 1'b1;
        idle();
        while (!s_valid && n < 10) begin
            idle();
            n++;
        end
        if (!s_valid) chk({name, "_timeout"}, 64'(s_valid), 64'd1);
    endtask

    task automatic reset_mid();
        @(negedge clk);
        rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        #1;
        chk("rst_valid_o", 64'(valid_o), 64'd0);
        chk("rst_z", z, 64'h0);
        chk("rst_ready_o", 64'(ready_o), 64'd1);
        q.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        chk("rst_hold_valid_o", 64'(valid_o), 64'd0);
        rst_n = 1'b1;
    endtask

    logic [63:0] rv;

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 7))
            0:       rnd64 = 64'h0;
            1:       rnd64 = 64'hFFFF_FFFF_FFFF_FFFF;
            2:       rnd64 = 64'h8000_0000_0000_0000;
            default: rnd64 = {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        int pending, sent, cyc, n;
        nvalid = 1'b0; nready = 1'b1; na = '0; nb = '0; nop = '0; ntag = '0;
        valid_i = 1'b0; ready_i = 1'b1; a = '0; b = '0; op = '0; tag_i = '0;
        rst_n = 1'b0;
        #2;
        chk("reset_valid_o", 64'(valid_o), 64'd0);
        chk("reset_z", z, 64'h0);
        chk("reset_tag_flags", 64'({tag_o, zero_o, carry_o, err_o}), 64'd0);
        chk("reset_ready_o", 64'(ready_o), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-stream: two accepted requests must vanish.
        send(64'd1, 64'd2, 4'd4, 4'd9);
        send(64'd3, 64'd4, 4'd4, 4'd10);
        reset_mid();
        repeat (6) idle();

        // Back-to-back arithmetic and shift.
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd4, 4'd1);
        send(64'd3, 64'd5, 4'd5, 4'd2);
        send(64'h8000_0000_0000_0000, 64'h43, 4'd9, 4'd3);
        wait_valid("b2b");
        chk("add_z", s_z, 64'h0);
        chk("add_zero_carry", 64'({s_zero, s_carry}), 64'b11);
        chk("add_tag", 64'(s_tag), 64'd1);
        idle();
        chk("sub_z", s_z, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("sub_borrow", 64'(s_carry), 64'd1);
        chk("sub_tag", 64'(s_tag), 64'd2);
        idle();
        chk("sra_z", s_z, 64'hF000_0000_0000_0000);
        chk("sra_tag", 64'(s_tag), 64'd3);

        // Population count.
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 4'd10, 4'd4);
        send(64'h0, 64'd0, 4'd10, 4'd5);
        send(64'h8000_0000_0000_0001, 64'd0, 4'd10, 4'd6);
        wait_valid("pop");
        chk("pop_all", s_z, 64'd64);
        idle();
        chk("pop_zero", 64'({s_z[7:0], s_zero}), 64'({8'd0, 1'b1}));
        idle();
        chk("pop_two", s_z, 64'd2);

        // Backpressure: three in flight, ready_i low for five cycles.
        repeat (3) idle();
        send(64'h11, 64'h22, 4'd2, 4'd1);
        send(64'h33, 64'h44, 4'd2, 4'd2);
        send(64'h55, 64'h66, 4'd2, 4'd3);
        nready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            idle();
            chk("bp_tag_held", 64'(s_tag), 64'd1);
            chk("bp_ready_o_low", 64'(ready_o), 64'd0);
        end
        nready = 1'b1;
        idle();
        chk("drain_tag1", 64'(s_tag), 64'd1);
        idle();
        chk("drain_tag2", 64'(s_tag), 64'd2);
        idle();
        chk("drain_tag3", 64'(s_tag), 64'd3);
        idle();
        chk("drain_empty", 64'(s_valid), 64'd0);

        // Undefined opcode, then a normal one.
        send(64'h1234, 64'h5678, 4'd13, 4'd7);
        wait_valid("undef");
        chk("undef_err", 64'({s_err, s_zero, s_carry}), 64'b110);
        chk("undef_z", s_z, 64'h0);
        chk("undef_tag", 64'(s_tag), 64'd7);
        send(64'd5, 64'd6, 4'd4, 4'd8);
        wait_valid("after_undef");
        chk("after_undef_err", 64'(s_err), 64'd0);
        chk("after_undef_z", s_z, 64'd11);

        // Random stream with random backpressure; upstream holds unaccepted requests.
        pending = 0; sent = 0; cyc = 0;
        while (sent < 10000 && cyc < 60000) begin
            if (pending == 0 && $urandom_range(0, 3) != 0) begin
                pending = 1;
                na = rnd64(); rv = rnd64(); nb = rv;
                nop = 4'($urandom_range(0, 15));
                ntag = 4'($urandom);
            end
            nvalid = (pending != 0);
            nready = ($urandom_range(0, 3) != 0);
            tick();
            cyc++;
            if (acc_in) begin
                pending = 0;
                sent++;
            end
        end
        chk("rand_sent", 64'(sent), 64'd10000);
        nvalid = 1'b0; nready = 1'b1;
        n = 0;
        while (q.size() > 0 && n < 20) begin
            tick();
            n++;
        end
        chk("rand_drained", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
